// File: rtl/game_pkg.sv
// Shared screen encodings and game constants for the LED racer.
// Latency: none (package only).
// Backpressure: none (package only).
package game_pkg;

    typedef enum logic [1:0] {
        SCREEN_MENU      = 2'b00,
        SCREEN_PLAY      = 2'b01,
        SCREEN_END       = 2'b10,
        SCREEN_COUNTDOWN = 2'b11
    } screen_t;

    // Number of visible countdown steps (3, 2, 1).
    localparam int COUNTDOWN_STEPS = 3;

endpackage

// File: rtl/game_screen_fsm_position_counter.sv
// Saturating per-player track position counter; clr has priority over inc.
// Latency: inc at edge N is visible in cycle N+1.
// Backpressure: none; increments past the finish are dropped by saturation.
module position_counter #(
    parameter int TRACK_LEN = 49,
    parameter int POS_W     = $clog2(TRACK_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [POS_W-1:0] count,
    output logic             at_finish,
    output logic             reach_finish
);

    localparam logic [POS_W-1:0] FINISH = POS_W'(TRACK_LEN - 1);

    // Position register: clear wins, otherwise count up until the finish LED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != FINISH)) begin
            count <= count + 1'b1;
        end
    end

    assign at_finish    = (count == FINISH);
    // This edge lands the player on the finish LED.
    assign reach_finish = inc && !clr && (count == (FINISH - POS_W'(1)));

endmodule

// File: rtl/game_screen_fsm.sv
// Game sequencer: MENU -> (COUNTDOWN, when START_COUNTDOWN_EN is defined) -> PLAY -> END.
// Latency: press or trigger_reset_all at edge N is reflected on all outputs in cycle N+1.
// Backpressure: none; presses outside MENU/PLAY are dropped, trigger_reset_all always wins.
module game_screen_fsm
    import game_pkg::*;
#(
    parameter int PLAYERS             = 4,
    parameter int TRACK_LEN           = 49,
    parameter int COUNTDOWN_CLK_COUNT = 1,
    parameter int POS_W               = $clog2(TRACK_LEN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PLAYERS-1:0]       btn_press,
    input  logic                     trigger_reset_all,
    output logic [1:0]               current_screen,
    output logic [PLAYERS*POS_W-1:0] positions,
    output logic [1:0]               winner,
    output logic                     winner_valid,
    output logic [1:0]               countdown_step
);

    screen_t              state;
    logic [PLAYERS-1:0]   done;
    logic                 any_done;
    logic [1:0]           win_idx;
    logic                 in_play;

    assign in_play        = (state == SCREEN_PLAY);
    assign current_screen = state;

    // One saturating counter per lane; moves only while racing.
    for (genvar g = 0; g < PLAYERS; g++) begin : g_lane
        logic lane_at_finish;
        logic lane_reach;

        position_counter #(
            .TRACK_LEN (TRACK_LEN),
            .POS_W     (POS_W)
        ) u_pos (
            .clk          (clk),
            .reset        (reset),
            .inc          (btn_press[g] && in_play),
            .clr          (trigger_reset_all),
            .count        (positions[g*POS_W +: POS_W]),
            .at_finish    (lane_at_finish),
            .reach_finish (lane_reach)
        );

        assign done[g] = in_play && (lane_reach || lane_at_finish);
    end

    assign any_done = |done;

    // Winner priority encoder: lowest lane index among this edge's finishers.
    always_comb begin
        win_idx = 2'd0;
        for (int i = PLAYERS - 1; i >= 0; i--) begin
            if (done[i]) begin
                win_idx = 2'(i);
            end
        end
    end

`ifdef START_COUNTDOWN_EN
    localparam int CD_W = (COUNTDOWN_CLK_COUNT > 1) ? $clog2(COUNTDOWN_CLK_COUNT) : 1;
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(COUNTDOWN_CLK_COUNT - 1);

    logic [CD_W-1:0] cd_cnt;
`else
    assign countdown_step = 2'd0;
`endif

    // Screen sequencer with registered winner and countdown outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SCREEN_MENU;
            winner       <= 2'd0;
            winner_valid <= 1'b0;
`ifdef START_COUNTDOWN_EN
            cd_cnt         <= '0;
            countdown_step <= 2'd0;
`endif
        end else if (trigger_reset_all) begin
            state        <= SCREEN_MENU;
            winner       <= 2'd0;
            winner_valid <= 1'b0;
`ifdef START_COUNTDOWN_EN
            cd_cnt         <= '0;
            countdown_step <= 2'd0;
`endif
        end else begin
            case (state)
                SCREEN_MENU: begin
                    if (|btn_press) begin
`ifdef START_COUNTDOWN_EN
                        state          <= SCREEN_COUNTDOWN;
                        countdown_step <= 2'(COUNTDOWN_STEPS);
                        cd_cnt         <= '0;
`else
                        state          <= SCREEN_PLAY;
`endif
                    end
                end
`ifdef START_COUNTDOWN_EN
                SCREEN_COUNTDOWN: begin
                    if (cd_cnt == CD_LAST) begin
                        cd_cnt <= '0;
                        if (countdown_step == 2'd1) begin
                            state          <= SCREEN_PLAY;
                            countdown_step <= 2'd0;
                        end else begin
                            countdown_step <= countdown_step - 2'd1;
                        end
                    end else begin
                        cd_cnt <= cd_cnt + 1'b1;
                    end
                end
`endif
                SCREEN_PLAY: begin
                    if (any_done) begin
                        state        <= SCREEN_END;
                        winner       <= win_idx;
                        winner_valid <= 1'b1;
                    end
                end
                SCREEN_END: begin
                    state <= SCREEN_END;
                end
                default: begin
                    state <= SCREEN_MENU;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_screen_fsm.sv
// Randomized plus directed bench for game_screen_fsm against a lane/screen reference model.
// Latency: model updates once per rising edge; outputs compared 1 ns after it.
// Backpressure: none; stimulus may press in any state.
module tb_game_screen_fsm;

    localparam int PLAYERS   = 4;
    localparam int TRACK_LEN = 49;
    localparam int CCC       = 4;
    localparam int POS_W     = $clog2(TRACK_LEN);
    localparam int FIN       = TRACK_LEN - 1;
`ifdef START_COUNTDOWN_EN
    localparam bit CD_ON = 1'b1;
`else
    localparam bit CD_ON = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic [PLAYERS-1:0]       btn;
    logic                     trig;
    logic [1:0]               current_screen;
    logic [PLAYERS*POS_W-1:0] positions;
    logic [1:0]               winner;
    logic                     winner_valid;
    logic [1:0]               countdown_step;

    game_screen_fsm #(
        .PLAYERS             (PLAYERS),
        .TRACK_LEN           (TRACK_LEN),
        .COUNTDOWN_CLK_COUNT (CCC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .btn_press         (btn),
        .trigger_reset_all (trig),
        .current_screen    (current_screen),
        .positions         (positions),
        .winner            (winner),
        .winner_valid      (winner_valid),
        .countdown_step    (countdown_step)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: 0 menu, 1 play, 2 end, 3 countdown (output encoding).
    int m_scr;
    int m_pos [PLAYERS];
    int m_win;
    int m_wv;
    int m_cd_elapsed;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pos_of(input int i);
        return int'(positions[i*POS_W +: POS_W]);
    endfunction

    function automatic void m_reset();
        m_scr = 0;
        m_win = 0;
        m_wv  = 0;
        m_cd_elapsed = 0;
        for (int i = 0; i < PLAYERS; i++) m_pos[i] = 0;
    endfunction

    function automatic int m_step();
        if (m_scr == 3) return 3 - (m_cd_elapsed / CCC);
        return 0;
    endfunction

    function automatic void model_edge(input logic [PLAYERS-1:0] p, input logic t);
        if (t) begin
            m_reset();
        end else if (m_scr == 0) begin
            if (p != '0) begin
                m_cd_elapsed = 0;
                m_scr = CD_ON ? 3 : 1;
            end
        end else if (m_scr == 3) begin
            m_cd_elapsed++;
            if (m_cd_elapsed == 3 * CCC) m_scr = 1;
        end else if (m_scr == 1) begin
            for (int i = 0; i < PLAYERS; i++)
                if (p[i] && m_pos[i] < FIN) m_pos[i]++;
            for (int i = PLAYERS - 1; i >= 0; i--) begin
                if (m_pos[i] == FIN) begin
                    m_scr = 2;
                    m_win = i;
                    m_wv  = 1;
                end
            end
        end
    endfunction

    task automatic check_all();
        chk("screen", int'(current_screen), m_scr);
        for (int i = 0; i < PLAYERS; i++) chk($sformatf("pos%0d", i), pos_of(i), m_pos[i]);
        chk("winner", int'(winner), m_win);
        chk("winner_valid", int'(winner_valid), m_wv);
        chk("countdown_step", int'(countdown_step), m_step());
    endtask

    task automatic step(input logic [PLAYERS-1:0] p, input logic t);
        btn  = p;
        trig = t;
        @(posedge clk);
        model_edge(p, t);
        #1;
        check_all();
        btn  = '0;
        trig = 1'b0;
    endtask

    task automatic go_play();
        step(4'b0100, 1'b0);
        for (int k = 0; k < 100 && m_scr != 1; k++) step('0, 1'b0);
        chk("reach_play", int'(current_screen), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        btn   = 4'b0100;
        trig  = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        btn   = '0;

        // Menu press, then P0 five presses with P1 on two of them.
        go_play();
        step(4'b0001, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b0001, 1'b0);
        chk("p0_five", pos_of(0), 5);
        chk("p1_two", pos_of(1), 2);

        // Reset-all during PLAY with a press.
        step(4'b0001, 1'b1);
        chk("rst_play_screen", int'(current_screen), 0);

        // P3 runs to the finish alone.
        go_play();
        repeat (47) step(4'b1000, 1'b0);
        chk("p3_at_47", pos_of(3), 47);
        step(4'b1000, 1'b0);
        chk("p3_end_screen", int'(current_screen), 2);
        chk("p3_winner", int'(winner), 3);
        chk("p3_valid", int'(winner_valid), 1);
        repeat (3) step(4'b1111, 1'b0);
        step(4'b1111, 1'b1);
        chk("rst_end_valid", int'(winner_valid), 0);

        // P1 and P2 finish together.
        go_play();
        repeat (48) step(4'b0110, 1'b0);
        chk("tie_winner", int'(winner), 1);
        step('0, 1'b1);

        // Async reset mid-game.
        go_play();
        repeat (3) step(4'b0001, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            logic [PLAYERS-1:0] p;
            logic t;
            for (int i = 0; i < PLAYERS; i++) p[i] = ($urandom_range(0, 9) < 6);
            t = ($urandom_range(0, 199) == 0) ||
                (m_scr == 2 && $urandom_range(0, 19) == 0);
            step(p, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
